// File: rtl/cam_pkg.sv
// Shared CAM definitions: geometry, opcodes and the arbiter FSM encoding.
package cam_pkg;

   localparam int CAM_DEPTH  = 32;
   localparam int CAM_IDX_W  = 5;
   localparam int CAM_DATA_W = 32;

   typedef enum logic [1:0] {
      OP_READ    = 2'd0,
      OP_WRITE   = 2'd1,
      OP_SEARCH  = 2'd2,
      OP_ILLEGAL = 2'd3
   } cam_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } cam_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant of the first request at or after the
// pointer; the pointer moves past the winner whenever a grant is taken.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               advance_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [ID_W-1:0]    grant_id_o,
   output logic               any_o
);

   logic [ID_W-1:0]    ptr_reg;
   logic [NUM_REQ-1:0] rot_req;
   logic [ID_W-1:0]    offset;
   logic [ID_W:0]      id_sum;

   // Rotate so bit 0 is the requester the pointer currently favours.
   assign rot_req = NUM_REQ'({req_i, req_i} >> ptr_reg);

   always_comb begin
      offset = '0;
      any_o  = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot_req[k]) begin
            offset = ID_W'(k);
            any_o  = 1'b1;
         end
      end
   end

   always_comb begin
      id_sum = {1'b0, ptr_reg} + {1'b0, offset};
      if (id_sum >= (ID_W + 1)'(NUM_REQ)) begin
         id_sum = id_sum - (ID_W + 1)'(NUM_REQ);
      end
      grant_id_o = id_sum[ID_W-1:0];
   end

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
         assign grant_o[gi] = any_o && (grant_id_o == ID_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ptr_reg <= '0;
      end else if (advance_i && any_o) begin
         ptr_reg <= (grant_id_o == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_o + ID_W'(1);
      end
   end

endmodule

// File: rtl/cam_arbiter.sv
// Round-robin sharing of one CAM among NUM_REQ requesters, one operation in flight.
// Optional macro CAM_ARB_WRITE_ACK_EN: WRITE commands return a hit=1 response pulse.
module cam_arbiter
   import cam_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int CAM_LATENCY = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic [2*NUM_REQ-1:0]          req_op_i,
   input  logic [CAM_IDX_W*NUM_REQ-1:0]  req_index_i,
   input  logic [CAM_DATA_W*NUM_REQ-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            rsp_valid_o,
   output logic                          rsp_hit_o,
   output logic                          rsp_err_o,
   output logic [CAM_IDX_W-1:0]          rsp_index_o,
   output logic [CAM_DATA_W-1:0]         rsp_data_o,
   output logic                          cam_read_enable_o,
   output logic                          cam_write_enable_o,
   output logic                          cam_search_enable_o,
   output logic [CAM_IDX_W-1:0]          cam_read_index_o,
   output logic [CAM_IDX_W-1:0]          cam_write_index_o,
   output logic [CAM_DATA_W-1:0]         cam_write_data_o,
   output logic [CAM_DATA_W-1:0]         cam_search_data_o,
   input  logic                          cam_read_valid_i,
   input  logic                          cam_search_valid_i,
   input  logic [CAM_DATA_W-1:0]         cam_read_value_i,
   input  logic [CAM_IDX_W-1:0]          cam_search_index_i
);

   localparam int         ID_W      = $clog2(NUM_REQ);
   localparam logic [1:0] WAIT_LAST = 2'(CAM_LATENCY - 1);

   logic [1:0]            op_arr    [NUM_REQ];
   logic [CAM_IDX_W-1:0]  index_arr [NUM_REQ];
   logic [CAM_DATA_W-1:0] data_arr  [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign op_arr[gi]    = req_op_i[gi*2 +: 2];
         assign index_arr[gi] = req_index_i[gi*CAM_IDX_W +: CAM_IDX_W];
         assign data_arr[gi]  = req_data_i[gi*CAM_DATA_W +: CAM_DATA_W];
      end
   endgenerate

   cam_arb_state_e        state_reg;
   cam_op_e               op_reg;
   logic [ID_W-1:0]       grant_reg;
   logic [1:0]            wait_cnt_reg;

   logic [NUM_REQ-1:0]    rsp_valid_reg;
   logic                  rsp_hit_reg;
   logic                  rsp_err_reg;
   logic [CAM_IDX_W-1:0]  rsp_index_reg;
   logic [CAM_DATA_W-1:0] rsp_data_reg;

   logic                  cam_rd_en_reg;
   logic                  cam_wr_en_reg;
   logic                  cam_sr_en_reg;
   logic [CAM_IDX_W-1:0]  cam_rd_idx_reg;
   logic [CAM_IDX_W-1:0]  cam_wr_idx_reg;
   logic [CAM_DATA_W-1:0] cam_wr_data_reg;
   logic [CAM_DATA_W-1:0] cam_sr_data_reg;

   logic [NUM_REQ-1:0]    arb_grant;
   logic [ID_W-1:0]       arb_id;
   logic                  arb_any;
   logic                  accept_en;
   cam_op_e               new_op;

   // Grants are only offered in IDLE and never while reset is being applied.
   assign accept_en = rst_i && (state_reg == IDLE);
   assign new_op    = cam_op_e'(op_arr[arb_id]);

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .req_i      (req_valid_i),
      .advance_i  (accept_en),
      .grant_o    (arb_grant),
      .grant_id_o (arb_id),
      .any_o      (arb_any)
   );

   assign req_ready_o = accept_en ? arb_grant : '0;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_reg       <= IDLE;
         op_reg          <= OP_READ;
         grant_reg       <= '0;
         wait_cnt_reg    <= '0;
         rsp_valid_reg   <= '0;
         rsp_hit_reg     <= 1'b0;
         rsp_err_reg     <= 1'b0;
         rsp_index_reg   <= '0;
         rsp_data_reg    <= '0;
         cam_rd_en_reg   <= 1'b0;
         cam_wr_en_reg   <= 1'b0;
         cam_sr_en_reg   <= 1'b0;
         cam_rd_idx_reg  <= '0;
         cam_wr_idx_reg  <= '0;
         cam_wr_data_reg <= '0;
         cam_sr_data_reg <= '0;
      end else begin
         // Enables and the response are single-cycle pulses; payloads read 0 otherwise.
         cam_rd_en_reg   <= 1'b0;
         cam_wr_en_reg   <= 1'b0;
         cam_sr_en_reg   <= 1'b0;
         cam_rd_idx_reg  <= '0;
         cam_wr_idx_reg  <= '0;
         cam_wr_data_reg <= '0;
         cam_sr_data_reg <= '0;
         rsp_valid_reg   <= '0;
         rsp_hit_reg     <= 1'b0;
         rsp_err_reg     <= 1'b0;
         rsp_index_reg   <= '0;
         rsp_data_reg    <= '0;

         case (state_reg)
            IDLE: begin
               if (arb_any) begin
                  op_reg    <= new_op;
                  grant_reg <= arb_id;
                  state_reg <= ISSUE;
                  case (new_op)
                     OP_READ: begin
                        cam_rd_en_reg  <= 1'b1;
                        cam_rd_idx_reg <= index_arr[arb_id];
                     end
                     OP_WRITE: begin
                        cam_wr_en_reg   <= 1'b1;
                        cam_wr_idx_reg  <= index_arr[arb_id];
                        cam_wr_data_reg <= data_arr[arb_id];
                     end
                     OP_SEARCH: begin
                        cam_sr_en_reg   <= 1'b1;
                        cam_sr_data_reg <= data_arr[arb_id];
                     end
                     OP_ILLEGAL: begin
                     end
                  endcase
               end
            end

            ISSUE: begin
               case (op_reg)
                  OP_READ, OP_SEARCH: begin
                     wait_cnt_reg <= '0;
                     state_reg    <= WAIT;
                  end
                  OP_WRITE: begin
`ifdef CAM_ARB_WRITE_ACK_EN
                     rsp_valid_reg <= NUM_REQ'(1) << grant_reg;
                     rsp_hit_reg   <= 1'b1;
                     state_reg     <= RESP;
`else
                     state_reg     <= IDLE;
`endif
                  end
                  OP_ILLEGAL: begin
                     rsp_valid_reg <= NUM_REQ'(1) << grant_reg;
                     rsp_err_reg   <= 1'b1;
                     state_reg     <= RESP;
                  end
               endcase
            end

            WAIT: begin
               if (wait_cnt_reg == WAIT_LAST) begin
                  rsp_valid_reg <= NUM_REQ'(1) << grant_reg;
                  if (op_reg == OP_READ) begin
                     rsp_hit_reg  <= cam_read_valid_i;
                     rsp_data_reg <= cam_read_value_i;
                  end else begin
                     rsp_hit_reg   <= cam_search_valid_i;
                     rsp_index_reg <= cam_search_index_i;
                  end
                  state_reg <= RESP;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 2'd1;
               end
            end

            RESP: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign rsp_valid_o         = rsp_valid_reg;
   assign rsp_hit_o           = rsp_hit_reg;
   assign rsp_err_o           = rsp_err_reg;
   assign rsp_index_o         = rsp_index_reg;
   assign rsp_data_o          = rsp_data_reg;
   assign cam_read_enable_o   = cam_rd_en_reg;
   assign cam_write_enable_o  = cam_wr_en_reg;
   assign cam_search_enable_o = cam_sr_en_reg;
   assign cam_read_index_o    = cam_rd_idx_reg;
   assign cam_write_index_o   = cam_wr_idx_reg;
   assign cam_write_data_o    = cam_wr_data_reg;
   assign cam_search_data_o   = cam_sr_data_reg;

endmodule
